seg_axi_regs: RTL and testbench

AXI4-Lite slave register block that sits directly upstream of the seven-segment display logic. It terminates PS-side AXI4-Lite transactions, holds the display data register, and drives the held data word plus a one-cycle update strobe into the display stage. It also exposes a read-back path and a committed-write counter for software checking.

---
 rtl/seg_axi_pkg.sv | 21 ++
 rtl/seg_axi_wr_ctrl.sv | 85 ++++++++
 rtl/seg_axi_regs.sv | 128 ++++++++++++
 tb/tb_seg_axi_regs.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_axi_pkg.sv
// Shared register-map constants, response codes and the write-commit bundle
// passed from the write controller to the register file.
package seg_axi_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [1:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_cmd_t;

  function automatic logic [1:0] resp_for(input logic [1:0] addr);
    return (addr == ADDR_DATA || addr == ADDR_STATUS) ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/seg_axi_wr_ctrl.sv
// AXI4-Lite write path: independent AW/W holding registers, commit strobe
// toward the register file, and the B response channel.
module seg_axi_wr_ctrl
  import seg_axi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic        commit,
  output wr_cmd_t     cmd
);

  logic        aw_held_q, aw_held_d;
  logic        w_held_q, w_held_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [1:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  strb_q, strb_d;

  always_comb begin
    // Ready is forced low while reset is held so nothing is accepted then.
    awready   = !rst && !aw_held_q && !bvalid_q;
    wready    = !rst && !w_held_q && !bvalid_q;
    commit    = aw_held_q && w_held_q && !bvalid_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    if (awvalid && awready) begin
      aw_held_d = 1'b1;
      addr_d    = awaddr;
    end
    if (wvalid && wready) begin
      w_held_d = 1'b1;
      data_d   = wdata;
      strb_d   = wstrb;
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = resp_for(addr_q);
    end else if (bvalid_q && bready) begin
      bvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
    end
  end

  assign bvalid = bvalid_q;
  assign bresp  = bresp_q;
  assign cmd    = '{addr: addr_q, data: data_q, strb: strb_q};

endmodule

// File: rtl/seg_axi_regs.sv
// AXI4-Lite register block feeding the seven-segment display: DATA register,
// committed-write counter in STATUS, read channel and display update strobe.
module seg_axi_regs
  import seg_axi_pkg::*;
#(
  parameter int seg_width          = 16,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [seg_width-1:0]            seg_wdata,
  output logic                            seg_wvalid
);

  logic    commit;
  wr_cmd_t cmd;

  logic [seg_width-1:0]          data_q, data_d;
  logic [15:0]                   wr_count_q, wr_count_d;
  logic                          seg_wvalid_q, seg_wvalid_d;
  logic                          rvalid_q, rvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                    rresp_q, rresp_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
  logic                          effective;
  logic                          unused_bits;

  seg_axi_wr_ctrl u_wr_ctrl (
    .clk     (s_axi_aclk),
    .rst     (s_axi_areset),
    .awaddr  (s_axi_awaddr[3:2]),
    .awvalid (s_axi_awvalid),
    .awready (s_axi_awready),
    .wdata   (s_axi_wdata),
    .wstrb   (s_axi_wstrb),
    .wvalid  (s_axi_wvalid),
    .wready  (s_axi_wready),
    .bresp   (s_axi_bresp),
    .bvalid  (s_axi_bvalid),
    .bready  (s_axi_bready),
    .commit  (commit),
    .cmd     (cmd)
  );

  always_comb begin
    data_d       = data_q;
    wr_count_d   = wr_count_q;
    seg_wvalid_d = 1'b0;
    effective    = 1'b0;
    // Only strobes for bytes that exist in the DATA register count as a write.
    if (commit && cmd.addr == ADDR_DATA) begin
      for (int unsigned i = 0; i < seg_width / 8; i++) begin
        if (cmd.strb[i]) begin
          data_d[i*8 +: 8] = cmd.data[i*8 +: 8];
          effective        = 1'b1;
        end
      end
      if (effective) begin
        wr_count_d   = wr_count_q + 16'd1;
        seg_wvalid_d = 1'b1;
      end
    end
  end

  always_comb begin
    s_axi_arready = !s_axi_areset && !rvalid_q;
    rd_word       = '0;
    case (s_axi_araddr[3:2])
      ADDR_DATA:   rd_word[seg_width-1:0] = data_q;
      ADDR_STATUS: rd_word[15:0]          = wr_count_q;
      default:     ;
    endcase
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (s_axi_arvalid && s_axi_arready) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
      rresp_d  = resp_for(s_axi_araddr[3:2]);
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      data_q       <= '0;
      wr_count_q   <= '0;
      seg_wvalid_q <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
    end else begin
      data_q       <= data_d;
      wr_count_q   <= wr_count_d;
      seg_wvalid_q <= seg_wvalid_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
    end
  end

  assign seg_wdata    = data_q;
  assign seg_wvalid   = seg_wvalid_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;
  assign unused_bits  = ^{s_axi_awaddr, s_axi_araddr, cmd};

endmodule

// File: tb/tb_seg_axi_regs.sv
// Randomized AXI4-Lite bench for seg_axi_regs with a transaction-level model
// of the DATA register, write counter and display strobe.
module tb_seg_axi_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, seg_wvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [15:0] seg_wdata;

  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  logic [15:0] m_data  = '0;
  logic [15:0] m_count = '0;
  logic        m_pulse = 1'b0;

  seg_axi_regs #(.seg_width(16), .C_S_AXI_ADDR_WIDTH(4), .C_S_AXI_DATA_WIDTH(32)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .seg_wdata(seg_wdata), .seg_wvalid(seg_wvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected handshake at %0t", name, $time);
  endtask

  function automatic void model_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
    case (a[3:2])
      2'd0:    begin d = {16'h0, m_data};  r = 2'b00; end
      2'd1:    begin d = {16'h0, m_count}; r = 2'b00; end
      default: begin d = 32'h0;            r = 2'b10; end
    endcase
  endfunction

  function automatic void apply_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [15:0] mask;
    mask    = {{8{s[1]}}, {8{s[0]}}};
    m_pulse = 1'b0;
    if (a[3:2] == 2'd0 && mask != 16'h0) begin
      m_data  = (m_data & ~mask) | (d[15:0] & mask);
      m_count = m_count + 16'd1;
      m_pulse = 1'b1;
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("seg_wdata", {16'h0, seg_wdata}, {16'h0, m_data});
      chk("seg_wvalid", {31'h0, seg_wvalid}, {31'h0, m_pulse});
    end
  end

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly,
                          input bit probe_aw, input bit rd_at_commit, input logic [3:0] rd_addr);
    bit aw_done = 1'b0, w_done = 1'b0, aw_hs, w_hs;
    int cyc = 0;
    logic [31:0] exp_rd;
    logic [1:0]  exp_rr, exp_b;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done)) begin
      awvalid = !aw_done && cyc >= aw_dly;
      wvalid  = !w_done && cyc >= w_dly;
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      aw_done |= aw_hs;
      w_done  |= w_hs;
      cyc++;
      if (cyc > 30) begin
        awvalid = 1'b0; wvalid = 1'b0;
        fail_timeout("wr_handshake");
        return;
      end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid_before_commit", {31'h0, bvalid}, 32'h0);
    exp_b = (addr[3:2] < 2'd2) ? 2'b00 : 2'b10;
    if (rd_at_commit) begin
      model_read(rd_addr, exp_rd, exp_rr);
      araddr = rd_addr; arvalid = 1'b1;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    apply_write(addr, data, strb);
    chk("bvalid_at_commit", {31'h0, bvalid}, 32'h1);
    chk("bresp", {30'h0, bresp}, {30'h0, exp_b});
    if (rd_at_commit) begin
      chk("rvalid_collide", {31'h0, rvalid}, 32'h1);
      chk("rdata_collide", rdata, exp_rd);
      chk("rresp_collide", {30'h0, rresp}, {30'h0, exp_rr});
      rready = 1'b1;
    end
    for (int i = 0; i < b_dly; i++) begin
      if (probe_aw) begin awaddr = 4'h0; awvalid = 1'b1; end
      @(negedge clk);
      chk("awready_blocked", {31'h0, awready}, 32'h0);
      chk("wready_blocked", {31'h0, wready}, 32'h0);
      chk("bvalid_held", {31'h0, bvalid}, 32'h1);
      chk("bresp_stable", {30'h0, bresp}, {30'h0, exp_b});
      @(posedge clk); #1;
      m_pulse = 1'b0; rready = 1'b0;
    end
    bready = 1'b1;
    @(negedge clk);
    chk("bvalid_hs", {31'h0, bvalid}, 32'h1);
    @(posedge clk); #1;
    bready = 1'b0; awvalid = 1'b0; m_pulse = 1'b0; rready = 1'b0;
    chk("bvalid_cleared", {31'h0, bvalid}, 32'h0);
    chk("awready_rerise", {31'h0, awready}, 32'h1);
    chk("wready_rerise", {31'h0, wready}, 32'h1);
  endtask

  task automatic do_read(input logic [3:0] addr, input logic [31:0] exp_d, input logic [1:0] exp_r,
                         input int r_dly);
    bit hs = 1'b0;
    int cyc = 0;
    araddr = addr; arvalid = 1'b1;
    while (!hs && cyc < 20) begin
      @(negedge clk);
      hs = arvalid && arready;
      @(posedge clk); #1;
      cyc++;
    end
    arvalid = 1'b0;
    if (!hs) begin
      fail_timeout("rd_handshake");
      return;
    end
    chk("rvalid", {31'h0, rvalid}, 32'h1);
    chk("rdata", rdata, exp_d);
    chk("rresp", {30'h0, rresp}, {30'h0, exp_r});
    repeat (r_dly) begin
      @(posedge clk); #1;
      chk("rvalid_held", {31'h0, rvalid}, 32'h1);
      chk("rdata_held", rdata, exp_d);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("rvalid_cleared", {31'h0, rvalid}, 32'h0);
  endtask

  task automatic rand_read();
    logic [3:0]  a;
    logic [31:0] d;
    logic [1:0]  r;
    a = 4'($urandom_range(0, 3) << 2);
    model_read(a, d, r);
    do_read(a, d, r, $urandom_range(0, 2));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awready", {31'h0, awready}, 32'h0);
    chk("rst_wready", {31'h0, wready}, 32'h0);
    chk("rst_arready", {31'h0, arready}, 32'h0);
    chk("rst_bvalid", {31'h0, bvalid}, 32'h0);
    chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("rst_bresp", {30'h0, bresp}, 32'h0);
    chk("rst_rresp", {30'h0, rresp}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_seg_wdata", {16'h0, seg_wdata}, 32'h0);
    chk("rst_seg_wvalid", {31'h0, seg_wvalid}, 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_awready", {31'h0, awready}, 32'h1);
    chk("post_rst_arready", {31'h0, arready}, 32'h1);
    mon_en = 1'b1;

    do_write(4'h0, 32'h0000A55A, 4'hF, 0, 0, 0, 1'b0, 1'b0, 4'h0);
    do_read(4'h0, 32'h0000A55A, 2'b00, 0);
    do_read(4'h4, 32'h00000001, 2'b00, 1);

    do_write(4'h0, 32'h00003400, 4'h2, 2, 0, 0, 1'b0, 1'b0, 4'h0);
    do_read(4'h0, 32'h0000345A, 2'b00, 0);

    do_write(4'h0, 32'h00001111, 4'hF, 0, 1, 5, 1'b1, 1'b0, 4'h0);
    do_read(4'h8, 32'h0, 2'b10, 0);
    do_read(4'hC, 32'h0, 2'b10, 0);
    do_write(4'h4, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 1'b0, 1'b0, 4'h0);
    do_read(4'h4, 32'h00000003, 2'b00, 0);
    do_write(4'h0, 32'h0000BEEF, 4'h0, 0, 0, 1, 1'b0, 1'b0, 4'h0);
    do_write(4'h0, 32'hBEEF0000, 4'hC, 0, 0, 0, 1'b0, 1'b0, 4'h0);
    do_read(4'h4, 32'h00000003, 2'b00, 0);
    do_read(4'h0, 32'h00001111, 2'b00, 0);
    do_write(4'hC, 32'h12345678, 4'hF, 1, 0, 0, 1'b0, 1'b0, 4'h0);

    do_write(4'h0, 32'h0000BEEF, 4'hF, 0, 0, 0, 1'b0, 1'b1, 4'h0);
    do_write(4'h0, 32'h00000042, 4'h1, 0, 0, 0, 1'b0, 1'b1, 4'h4);

    force dut.wr_count_q = 16'hFFFF;
    #1;
    release dut.wr_count_q;
    m_count = 16'hFFFF;
    do_read(4'h4, 32'h0000FFFF, 2'b00, 0);
    do_write(4'h0, 32'h00000077, 4'h1, 0, 0, 0, 1'b0, 1'b0, 4'h0);
    do_read(4'h4, 32'h00000000, 2'b00, 0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        do_write(4'($urandom_range(0, 3) << 2), $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                 4'($urandom_range(0, 3) << 2));
      end else begin
        rand_read();
      end
    end

    do_write(4'h0, 32'h00005AA5, 4'h3, 0, 0, 0, 1'b0, 1'b0, 4'h0);
    araddr = 4'h0; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("pre_rst_rvalid", {31'h0, rvalid}, 32'h1);
    awaddr = 4'h0; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("aw_held_awready", {31'h0, awready}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    m_data = '0; m_count = '0; m_pulse = 1'b0;
    chk("midrst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("midrst_bvalid", {31'h0, bvalid}, 32'h0);
    chk("midrst_seg_wdata", {16'h0, seg_wdata}, 32'h0);
    chk("midrst_awready", {31'h0, awready}, 32'h0);
    rst = 1'b0;
    #1;
    chk("after_rst_awready", {31'h0, awready}, 32'h1);
    repeat (6) begin
      @(posedge clk); #1;
      chk("dropped_no_bvalid", {31'h0, bvalid}, 32'h0);
    end
    do_read(4'h4, 32'h00000000, 2'b00, 0);
    do_read(4'h0, 32'h00000000, 2'b00, 0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

endmodule
